// File: rtl/cp0_intc.sv
// Coprocessor-0 for the single-cycle MIPS core: Status/Cause/EPC/Count/Compare,
// level/edge interrupt arbitration plus a prescaled timer channel.
module cp0_intc #(
    parameter int         NUM_IRQ   = 4,
    parameter logic [6:0] EDGE_MASK = 7'b0000000,
    parameter int         PRESCALE  = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [4:0]         regnum,
    input  logic [31:0]        wr_data,
    input  logic               MTC0,
    input  logic               ERET,
    input  logic [29:0]        next_pc,
    output logic [31:0]        rd_data,
    output logic [29:0]        epc,
    output logic               takenInterrupt
);

    localparam logic [6:0] CH_MASK   = 7'((8'd1 << NUM_IRQ) - 8'd1);
    localparam logic [6:0] EDGE_CH   = EDGE_MASK & CH_MASK;
    localparam logic [7:0] PRESC_MAX = 8'(PRESCALE - 1);

    logic        ie_q, ie_d, exl_q, exl_d;
    logic [7:0]  im_q, im_d;
    logic [6:0]  edge_ip_q, edge_ip_d;
    logic [6:0]  irq_prev_q, irq_prev_d;
    logic        timer_ip_q, timer_ip_d;
    logic [29:0] epc_q, epc_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic [7:0]  presc_q, presc_d;

    logic [6:0]  irq_pad;
    logic [7:0]  ip;
    logic        wr_count, wr_compare, wr_status, wr_cause, wr_epc;
    logic        presc_wrap;

    // Level channels pass straight through; edge channels show their latched bit.
    always_comb begin
        irq_pad        = 7'(irq) & CH_MASK;
        ip             = {timer_ip_q, (edge_ip_q & EDGE_CH) | (irq_pad & ~EDGE_CH)};
        takenInterrupt = ie_q & ~exl_q & (|(ip & im_q));
        epc            = epc_q;
        wr_count       = MTC0 && (regnum == 5'd9);
        wr_compare     = MTC0 && (regnum == 5'd11);
        wr_status      = MTC0 && (regnum == 5'd12);
        wr_cause       = MTC0 && (regnum == 5'd13);
        wr_epc         = MTC0 && (regnum == 5'd14);
        presc_wrap     = (presc_q == PRESC_MAX);
    end

    always_comb begin
        ie_d        = ie_q;
        exl_d       = exl_q;
        im_d        = im_q;
        epc_d       = epc_q;
        count_d     = count_q;
        compare_d   = compare_q;
        presc_d     = presc_q;
        timer_ip_d  = timer_ip_q;
        irq_prev_d  = irq_pad;

        // A new rising edge beats a same-cycle write-1-to-clear.
        edge_ip_d = edge_ip_q;
        if (wr_cause)
            edge_ip_d = edge_ip_d & ~wr_data[14:8];
        edge_ip_d = (edge_ip_d | (irq_pad & ~irq_prev_q)) & EDGE_CH;

        if (wr_compare) begin
            compare_d  = wr_data;
            timer_ip_d = 1'b0;
        end

        // Loading Count restarts the prescaler and never raises a match by itself.
        if (wr_count) begin
            count_d = wr_data;
            presc_d = 8'd0;
        end else if (presc_wrap) begin
            presc_d = 8'd0;
            count_d = count_q + 32'd1;
            if (count_q + 32'd1 == compare_q)
                timer_ip_d = 1'b1;
        end else begin
            presc_d = presc_q + 8'd1;
        end

        if (wr_status) begin
            ie_d  = wr_data[0];
            exl_d = wr_data[1];
            im_d  = wr_data[15:8];
        end
        if (wr_epc)
            epc_d = wr_data[31:2];
        if (ERET)
            exl_d = 1'b0;

        if (takenInterrupt) begin
            exl_d = 1'b1;
            epc_d = next_pc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ie_q       <= 1'b0;
            exl_q      <= 1'b0;
            im_q       <= 8'd0;
            edge_ip_q  <= 7'd0;
            irq_prev_q <= 7'd0;
            timer_ip_q <= 1'b0;
            epc_q      <= 30'd0;
            count_q    <= 32'd0;
            compare_q  <= 32'hFFFF_FFFF;
            presc_q    <= 8'd0;
        end else begin
            ie_q       <= ie_d;
            exl_q      <= exl_d;
            im_q       <= im_d;
            edge_ip_q  <= edge_ip_d;
            irq_prev_q <= irq_prev_d;
            timer_ip_q <= timer_ip_d;
            epc_q      <= epc_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            presc_q    <= presc_d;
        end
    end

    always_comb begin
        rd_data = 32'd0;
        case (regnum)
            5'd9:    rd_data = count_q;
            5'd11:   rd_data = compare_q;
            5'd12:   rd_data = {16'd0, im_q, 6'd0, exl_q, ie_q};
            5'd13:   rd_data = {16'd0, ip, 8'd0};
            5'd14:   rd_data = {epc_q, 2'b00};
            default: rd_data = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_cp0_intc.sv
// Directed bench for cp0_intc: expectations are queued by the stimulus and
// checked by an independent monitor on every falling clock edge.
module tb_cp0_intc;

    localparam int NUM_IRQ = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic [NUM_IRQ-1:0] irq;
    logic [4:0]         regnum;
    logic [31:0]        wr_data;
    logic               MTC0;
    logic               ERET;
    logic [29:0]        next_pc;
    logic [31:0]        rd_data;
    logic [29:0]        epc;
    logic               takenInterrupt;

    cp0_intc #(
        .NUM_IRQ   (NUM_IRQ),
        .EDGE_MASK (7'b0000001),
        .PRESCALE  (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .irq            (irq),
        .regnum         (regnum),
        .wr_data        (wr_data),
        .MTC0           (MTC0),
        .ERET           (ERET),
        .next_pc        (next_pc),
        .rd_data        (rd_data),
        .epc            (epc),
        .takenInterrupt (takenInterrupt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] val;
    } exp_t;

    localparam logic [1:0] K_RD  = 2'd0;
    localparam logic [1:0] K_TI  = 2'd1;
    localparam logic [1:0] K_EPC = 2'd2;

    exp_t  exp_q[$];
    string name_q[$];
    int    total = 0;
    int    bad   = 0;

    exp_t        mon_e;
    string       mon_n;
    logic [31:0] mon_act;

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_n = name_q.pop_front();
            case (mon_e.kind)
                K_RD:    mon_act = rd_data;
                K_TI:    mon_act = {31'd0, takenInterrupt};
                default: mon_act = {2'd0, epc};
            endcase
            total++;
            if (mon_act !== mon_e.val) begin
                bad++;
                $display("FAIL %s: got %h expected %h", mon_n, mon_act, mon_e.val);
            end
        end
    end

    task automatic push(input logic [1:0] k, input logic [31:0] v, input string n);
        exp_t e;
        e.kind = k;
        e.val  = v;
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] r, input logic [31:0] v, input string n);
        regnum = r;
        push(K_RD, v, n);
        tick();
    endtask

    task automatic wr(input logic [4:0] r, input logic [31:0] v);
        regnum  = r;
        wr_data = v;
        MTC0    = 1'b1;
        tick();
        MTC0    = 1'b0;
    endtask

    task automatic chk_ti(input logic v, input string n);
        push(K_TI, {31'd0, v}, n);
    endtask

    task automatic chk_epc(input logic [29:0] v, input string n);
        push(K_EPC, {2'd0, v}, n);
    endtask

    localparam logic [29:0] PC_T = 30'h0ABC_DEF0;
    localparam logic [29:0] PC_L = 30'h0000_1111;
    localparam logic [29:0] PC1  = 30'h0000_2222;
    localparam logic [29:0] PC2  = 30'h0000_3333;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset   = 1'b0;
        irq     = '0;
        regnum  = 5'd0;
        wr_data = 32'd0;
        MTC0    = 1'b0;
        ERET    = 1'b0;
        next_pc = 30'd0;
        repeat (2) tick();
        reset = 1'b1;

        // Reset values
        chk_ti(1'b0, "rst_ti");
        rd(5'd9,  32'd0,        "rst_count");
        rd(5'd11, 32'hFFFF_FFFF, "rst_compare");
        rd(5'd12, 32'd0,        "rst_status");
        rd(5'd13, 32'd0,        "rst_cause");
        chk_epc(30'd0, "rst_epc");
        rd(5'd14, 32'd0,        "rst_epc_reg");

        // Timer: Count reaches Compare=5 on the 20th edge after the Count load
        wr(5'd9,  32'd0);
        wr(5'd11, 32'd5);
        wr(5'd12, 32'h8001);
        repeat (17) tick();
        chk_ti(1'b0, "tmr_ti_before");
        rd(5'd13, 32'd0, "tmr_ip_before");
        next_pc = PC_T;
        chk_ti(1'b1, "tmr_ti_match");
        rd(5'd13, 32'h8000, "tmr_ip_match");
        chk_epc(PC_T, "tmr_epc");
        chk_ti(1'b0, "tmr_exl_masks");
        rd(5'd14, {PC_T, 2'b00}, "tmr_epc_reg");
        rd(5'd12, 32'h8003, "tmr_status_exl");
        rd(5'd9,  32'd5,    "tmr_count");
        wr(5'd11, 32'hFFFF_0000);
        rd(5'd13, 32'd0, "tmr_ip_cleared");
        wr(5'd12, 32'd0);

        // Edge channel irq[0]
        irq = 4'b0001;
        tick();
        irq = 4'b0000;
        rd(5'd13, 32'h100, "edge_set");
        rd(5'd13, 32'h100, "edge_held");
        wr(5'd13, 32'h100);
        rd(5'd13, 32'd0, "edge_w1c");
        irq = 4'b0001;
        wr(5'd13, 32'h100);
        irq = 4'b0000;
        rd(5'd13, 32'h100, "edge_set_wins");
        wr(5'd13, 32'h100);
        rd(5'd13, 32'd0, "edge_w1c_again");

        // Level channel irq[1]
        wr(5'd12, 32'h1);
        irq = 4'b0010;
        chk_ti(1'b0, "lvl_masked_ti");
        rd(5'd13, 32'h200, "lvl_ip");
        wr(5'd12, 32'h201);
        next_pc = PC_L;
        chk_ti(1'b1, "lvl_ti");
        regnum = 5'd13;
        push(K_RD, 32'h200, "lvl_ip_unmasked");
        @(negedge clk);
        #1;
        irq = 4'b0000;
        tick();
        chk_ti(1'b0, "lvl_drop_ti");
        chk_epc(PC_T, "lvl_epc_kept");
        rd(5'd13, 32'd0,   "lvl_drop_ip");
        rd(5'd12, 32'h201, "lvl_exl_clear");

        // Service, masking by EXL, then ERET
        wr(5'd12, 32'h601);
        next_pc = PC1;
        irq = 4'b0010;
        chk_ti(1'b1, "svc_first_ti");
        rd(5'd13, 32'h200, "svc_first_ip");
        irq = 4'b0100;
        next_pc = PC2;
        chk_ti(1'b0, "svc_exl_masks");
        chk_epc(PC1, "svc_epc1");
        rd(5'd12, 32'h603, "svc_status_exl");
        ERET = 1'b1;
        chk_ti(1'b0, "svc_eret_ti");
        rd(5'd13, 32'h400, "svc_second_ip");
        ERET = 1'b0;
        chk_ti(1'b1, "svc_second_ti");
        chk_epc(PC1, "svc_epc1_after_eret");
        rd(5'd12, 32'h601, "svc_exl_cleared");
        chk_epc(PC2, "svc_epc2");
        rd(5'd12, 32'h603, "svc_second_taken");

        // Asynchronous reset between edges
        irq = 4'b0000;
        wr(5'd9, 32'd37);
        rd(5'd9,  32'd37,  "ar_count_pre");
        rd(5'd12, 32'h603, "ar_exl_pre");
        #2;
        reset  = 1'b0;
        regnum = 5'd9;
        push(K_RD, 32'd0, "ar_count");
        chk_ti(1'b0, "ar_ti");
        chk_epc(30'd0, "ar_epc");
        @(negedge clk);
        #1;
        regnum = 5'd12;
        push(K_RD, 32'd0, "ar_status");
        @(negedge clk);
        #1;
        regnum = 5'd11;
        push(K_RD, 32'hFFFF_FFFF, "ar_compare");
        @(negedge clk);
        #1;
        regnum = 5'd13;
        push(K_RD, 32'd0, "ar_cause");
        @(negedge clk);
        #1;
        reset  = 1'b1;
        regnum = 5'd0;
        push(K_RD, 32'd0, "unmapped_read");
        @(negedge clk);
        #1;

        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
